// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, pixel word layout and small helpers for the scanout block.
package vga_timing_pkg;

  localparam int PIX_W = 8;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Incoming pixel word: [7:6] red, [5:4] green, [3:2] blue, [1:0] unused
  localparam int RED_HI = 7;
  localparam int BLU_LO = 2;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  function automatic int span4(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

  function automatic rgb222_t to_rgb(input logic [5:0] w);
    rgb222_t p;
    p.r = w[5:4];
    p.g = w[3:2];
    p.b = w[1:0];
    return p;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// First-word-fall-through pixel buffer; dout shows the head combinationally.
// Pointers carry a wrap bit so full/empty are exact; flush beats a same-edge push.
module pixel_fifo
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr == {~r_rd[AW], r_rd[AW-1:0]});
  assign o_dout    = r_mem[r_rd[AW-1:0]];
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: strobe/ack intake into a small FIFO, pixel-tick raster, registered pins.
// Intake stalls (no ack) while the FIFO is full, disabled, or being flushed at frame start.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int PIX_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PIX_W-1:0] data_i,
  input  logic             stb_i,
  output logic             ack_i,
  output logic [1:0]       red,
  output logic [1:0]       green,
  output logic [1:0]       blue,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_sync,
  output logic [7:0]       underrun_cnt,
  input  logic             underrun_clr
);

  localparam int H_TOTAL = span4(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span4(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [HW-1:0] HX_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HX_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VY_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VY_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_hx;
  logic [VW-1:0] r_vy;
  logic          r_en_d;
  logic          r_ack;

  logic [HW-1:0]    w_hx_nxt;
  logic [VW-1:0]    w_vy_nxt;
  logic             w_hx_end;
  logic             w_vy_end;
  logic             w_tick;
  logic             w_rise;
  logic             w_adv;
  logic             w_wrap;
  logic             w_act_nxt;
  logic             w_pop;
  logic             w_push;
  logic             w_flush;
  logic             w_starve;
  logic             w_full;
  logic             w_empty;
  logic [PIX_W-1:0] w_head;
  rgb222_t          w_pix;
  logic             w_unused_lsbs;

  assign w_tick    = (r_div == DIV_LAST);
  assign w_hx_end  = (r_hx == HX_LAST);
  assign w_vy_end  = (r_vy == VY_LAST);
  assign w_hx_nxt  = w_hx_end ? '0 : r_hx + 1'b1;
  assign w_vy_nxt  = !w_hx_end ? r_vy : (w_vy_end ? '0 : r_vy + 1'b1);
  assign w_rise    = enable & ~r_en_d;
  assign w_adv     = enable & r_en_d & w_tick;
  assign w_wrap    = w_adv & w_hx_end & w_vy_end;
  assign w_act_nxt = (w_hx_nxt < HX_ACT) && (w_vy_nxt < VY_ACT);
  assign w_pop     = w_adv & w_act_nxt & ~w_empty;
  assign w_starve  = w_adv & w_act_nxt & w_empty;
  assign w_flush   = ~enable | w_rise | w_wrap;
  // While ack is high upstream still holds the word just taken, so the strobe is ignored.
  assign w_push    = stb_i & ~r_ack & ~w_full & enable & ~w_flush;
  assign ack_i     = r_ack;

  assign w_pix         = to_rgb(w_head[RED_HI:BLU_LO]);
  assign w_unused_lsbs = ^w_head[BLU_LO-1:0];

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (data_i),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dout  (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div        <= '0;
      r_hx         <= '0;
      r_vy         <= '0;
      r_en_d       <= 1'b0;
      r_ack        <= 1'b0;
      frame_sync   <= 1'b0;
      underrun_cnt <= '0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      de           <= 1'b0;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
    end else begin
      r_en_d     <= enable;
      r_ack      <= w_push;
      frame_sync <= w_rise | w_wrap;

      if (underrun_clr)
        underrun_cnt <= '0;
      else if (w_starve && underrun_cnt != 8'hFF)
        underrun_cnt <= underrun_cnt + 8'd1;

      // The enable edge restarts at (0,0) with blank pins; the first tick then shows (1,0).
      if (!enable || w_rise) begin
        r_div <= '0;
        r_hx  <= '0;
        r_vy  <= '0;
        hsync <= 1'b1;
        vsync <= 1'b1;
        de    <= 1'b0;
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          r_hx  <= w_hx_nxt;
          r_vy  <= w_vy_nxt;
          de    <= w_act_nxt;
          hsync <= !((w_hx_nxt >= HS_BEG) && (w_hx_nxt < HS_END));
          vsync <= !((w_vy_nxt >= VS_BEG) && (w_vy_nxt < VS_END));
          red   <= w_pop ? w_pix.r : 2'd0;
          green <= w_pop ? w_pix.g : 2'd0;
          blue  <= w_pop ? w_pix.b : 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken 16x11 raster (8x6 active) with PIX_DIV=2.
module tb_vga_scanout;

  // hsync low hx 10..12, vsync low vy 7..8, 352 clk per frame
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] data_i;
  logic       stb_i;
  logic       ack_i;
  logic [1:0] red, green, blue;
  logic       hsync, vsync, de, frame_sync;
  logic [7:0] underrun_cnt;
  logic       underrun_clr;

  int errors = 0;
  int checks = 0;

  logic [7:0] src_mem [16];
  int  src_rd = 0;
  int  src_wr = 0;
  logic src_en = 1'b0;
  logic src_inf = 1'b0;

  int fs_age = 0, de_cyc = 0, hs_cyc = 0, vs_cyc = 0, hs_first = -1, vs_first = -1;
  int last_period = 0, last_de = 0, last_hs = 0, last_vs = 0;
  int ack_total = 0, ack_wide = 0;
  logic ack_prev = 1'b0;

  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .PIX_DIV(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_i(data_i), .stb_i(stb_i), .ack_i(ack_i),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_sync(frame_sync), .underrun_cnt(underrun_cnt), .underrun_clr(underrun_clr)
  );

  // Upstream model: holds a word until acknowledged, then presents the next one.
  assign stb_i  = src_en && (src_inf || (src_rd != src_wr));
  assign data_i = (src_rd != src_wr) ? src_mem[src_rd % 16] : 8'hFC;

  always @(negedge clk) begin
    if (ack_i && (src_rd != src_wr)) src_rd++;
  end

  always @(negedge clk) begin
    if (ack_i) begin
      ack_total++;
      if (ack_prev) ack_wide++;
    end
    ack_prev = ack_i;
    if (frame_sync) begin
      last_period = fs_age + 1;
      last_de = de_cyc; last_hs = hs_cyc; last_vs = vs_cyc;
      fs_age = 0; de_cyc = 0; hs_cyc = 0; vs_cyc = 0; hs_first = -1; vs_first = -1;
    end else begin
      fs_age++;
    end
    if (de) de_cyc++;
    if (!hsync) begin hs_cyc++; if (hs_first < 0) hs_first = fs_age; end
    if (!vsync) begin vs_cyc++; if (vs_first < 0) vs_first = fs_age; end
  end

  task automatic wait_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin wait_cycle(); n++; end while (!frame_sync && n < 2000);
    if (!frame_sync) begin
      checks++; errors++;
      $display("FAIL wait_fs: frame_sync=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic wait_age(input int a);
    int n = 0;
    do begin wait_cycle(); n++; end while (fs_age != a && n < 2000);
    if (fs_age != a) begin
      checks++; errors++;
      $display("FAIL wait_age: age=%0d required %0d", fs_age, a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1; underrun_clr = 1'b0; src_en = 1'b1; src_inf = 1'b1;
    repeat (3) wait_cycle();
    checks++; if (ack_i !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack_i); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vsync); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", de); end
    checks++; if ({red, green, blue} !== 6'h00) begin errors++; $display("FAIL reset_rgb: got %h want 00", {red, green, blue}); end
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_underrun: got %0d want 0", underrun_cnt); end
    checks++; if (frame_sync !== 1'b0) begin errors++; $display("FAIL reset_fsync: got %b want 0", frame_sync); end
    enable = 1'b0; src_en = 1'b0; src_inf = 1'b0;
    wait_cycle();
    rst = 1'b1;
    repeat (3) wait_cycle();
  endtask

  task automatic test_handshake();
    logic [7:0] words [4] = '{8'hFC, 8'h30, 8'h0C, 8'hC0};
    logic [5:0] expv [4] = '{6'h3F, 6'h0C, 6'h03, 6'h30};
    int base;
    for (int i = 0; i < 4; i++) begin src_mem[src_wr % 16] = words[i]; src_wr++; end
    base = ack_total;
    src_en = 1'b1;
    enable = 1'b1;
    wait_fs();
    for (int i = 0; i < 4; i++) begin
      wait_age(2 + 2 * i);
      checks++;
      if (de !== 1'b1 || {red, green, blue} !== expv[i])
        begin errors++; $display("FAIL hs_pixel%0d: de=%b rgb=%h want de=1 rgb=%h", i, de, {red, green, blue}, expv[i]); end
    end
    wait_age(20);
    checks++; if (ack_total - base !== 4) begin errors++; $display("FAIL hs_ack_count: got %0d want 4", ack_total - base); end
    checks++; if (ack_wide !== 0) begin errors++; $display("FAIL hs_ack_width: wide acks %0d want 0", ack_wide); end
    checks++; if (src_rd !== src_wr) begin errors++; $display("FAIL hs_consumed: rd=%0d want %0d", src_rd, src_wr); end
  endtask

  task automatic test_timing();
    src_inf = 1'b1; src_en = 1'b1;
    wait_fs();
    wait_fs();
    checks++; if (last_period !== 352) begin errors++; $display("FAIL tm_period: got %0d want 352", last_period); end
    checks++; if (last_de !== 96) begin errors++; $display("FAIL tm_de: got %0d want 96", last_de); end
    checks++; if (last_hs !== 66) begin errors++; $display("FAIL tm_hsync_len: got %0d want 66", last_hs); end
    checks++; if (last_vs !== 64) begin errors++; $display("FAIL tm_vsync_len: got %0d want 64", last_vs); end
    wait_age(230);
    checks++; if (hs_first !== 20) begin errors++; $display("FAIL tm_hsync_start: got %0d want 20", hs_first); end
    checks++; if (vs_first !== 224) begin errors++; $display("FAIL tm_vsync_start: got %0d want 224", vs_first); end
  endtask

  task automatic test_full_flush();
    int a0, a1, a2, u0;
    underrun_clr = 1'b1; wait_cycle(); underrun_clr = 1'b0;
    wait_age(176); a0 = ack_total;
    wait_age(200); a1 = ack_total;
    wait_age(350); a2 = ack_total;
    checks++; if (a1 - a0 > 4) begin errors++; $display("FAIL ff_fill: got %0d acks want at most 4", a1 - a0); end
    checks++; if (a2 !== a1) begin errors++; $display("FAIL ff_full_ack: got %0d acks while full want 0", a2 - a1); end
    wait_fs();
    src_en = 1'b0;
    wait_cycle();
    checks++; if (frame_sync !== 1'b0) begin errors++; $display("FAIL ff_fsync_width: got %b want 0", frame_sync); end
    u0 = int'(underrun_cnt);
    wait_cycle();
    checks++; if (int'(underrun_cnt) !== u0 + 1) begin errors++; $display("FAIL ff_flushed: underrun %0d want %0d", underrun_cnt, u0 + 1); end
    checks++; if (de !== 1'b1 || {red, green, blue} !== 6'h00) begin errors++; $display("FAIL ff_blank_pix: de=%b rgb=%h want 1/00", de, {red, green, blue}); end
  endtask

  task automatic test_underrun();
    wait_fs();
    underrun_clr = 1'b1; wait_cycle(); underrun_clr = 1'b0;
    wait_age(72);
    checks++; if (underrun_cnt !== 8'd20) begin errors++; $display("FAIL ur_count: got %0d want 20", underrun_cnt); end
    checks++; if (de !== 1'b1 || {red, green, blue} !== 6'h00) begin errors++; $display("FAIL ur_pix: de=%b rgb=%h want 1/00", de, {red, green, blue}); end
    wait_age(73);
    underrun_clr = 1'b1; wait_cycle(); underrun_clr = 1'b0;
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL ur_clr_wins: got %0d want 0", underrun_cnt); end
    wait_age(76);
    checks++; if (underrun_cnt !== 8'd1) begin errors++; $display("FAIL ur_resume: got %0d want 1", underrun_cnt); end
  endtask

  task automatic test_enable_toggle();
    int a0;
    src_en = 1'b1; src_inf = 1'b1;
    wait_age(40);
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL en_pre_de: got %b want 1", de); end
    enable = 1'b0;
    wait_cycle();
    checks++; if (de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1)
      begin errors++; $display("FAIL en_low_sync: de=%b hs=%b vs=%b want 0/1/1", de, hsync, vsync); end
    checks++; if ({red, green, blue} !== 6'h00 || frame_sync !== 1'b0)
      begin errors++; $display("FAIL en_low_pix: rgb=%h fs=%b want 00/0", {red, green, blue}, frame_sync); end
    a0 = ack_total;
    repeat (4) wait_cycle();
    checks++; if (ack_total !== a0 || ack_i !== 1'b0) begin errors++; $display("FAIL en_low_ack: acks %0d want 0", ack_total - a0); end
    enable = 1'b1;
    wait_cycle();
    checks++; if (frame_sync !== 1'b1) begin errors++; $display("FAIL en_rise_fsync: got %b want 1", frame_sync); end
    wait_age(2);
    checks++; if (de !== 1'b1 || {red, green, blue} !== 6'h3F)
      begin errors++; $display("FAIL en_first_pix: de=%b rgb=%h want 1/3f", de, {red, green, blue}); end
    wait_age(22);
    checks++; if (hs_first !== 20) begin errors++; $display("FAIL en_restart_hsync: got %0d want 20", hs_first); end
  endtask

  task automatic test_saturate_and_async_reset();
    src_en = 1'b0;
    underrun_clr = 1'b1; wait_cycle(); underrun_clr = 1'b0;
    repeat (7) wait_fs();
    checks++; if (underrun_cnt !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", underrun_cnt); end
    wait_age(21);
    checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL ar_pre_hsync: got %b want 0", hsync); end
    rst = 1'b0;
    #1;
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL ar_hsync: got %b want 1", hsync); end
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL ar_underrun: got %0d want 0", underrun_cnt); end
    repeat (2) wait_cycle();
    rst = 1'b1;
    wait_cycle();
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_timing();
    test_full_flush();
    test_underrun();
    test_enable_toggle();
    test_saturate_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
